// File: rtl/register_file_mp.sv
// Multi-port register file with same-cycle write forwarding and an integrated
// busy-bit scoreboard (issue reserves a destination, writeback releases it).

module register_file_mp_rd_port #(
  parameter int XLEN      = 32,
  parameter int ADDR_W    = 5,
  parameter int NUM_WRITE = 2
) (
  input  logic [ADDR_W-1:0]                   addr,
  input  logic [(1<<ADDR_W)-1:0][XLEN-1:0]    regs_q,
  input  logic [(1<<ADDR_W)-1:0]              busy_q,
  input  logic                                fwd_en,
  input  logic [NUM_WRITE-1:0]                wr_en,
  input  logic [NUM_WRITE-1:0][ADDR_W-1:0]    wr_addr,
  input  logic [NUM_WRITE-1:0][XLEN-1:0]      wr_data,
  output logic [XLEN-1:0]                     data,
  output logic                                busy
);
  logic hit;

  // Ascending scan so the highest-index matching write port wins.
  always_comb begin
    data = regs_q[addr];
    hit  = 1'b0;
    if (fwd_en) begin
      for (int p = 0; p < NUM_WRITE; p++) begin
        if (wr_en[p] && (wr_addr[p] == addr)) begin
          data = wr_data[p];
          hit  = 1'b1;
        end
      end
    end
    busy = busy_q[addr] & ~hit;
    if (addr == '0) begin
      data = '0;
      busy = 1'b0;
    end
  end
endmodule

module register_file_mp #(
  parameter int XLEN           = 32,
  parameter int ADDR_W         = 5,
  parameter int NUM_READ       = 2,
  parameter int NUM_WRITE      = 2,
  parameter int USE_FORWARDING = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_READ-1:0][ADDR_W-1:0]  rd_addr,
  output logic [NUM_READ-1:0][XLEN-1:0]    rd_data,
  output logic [NUM_READ-1:0]              rd_busy,
  input  logic [NUM_WRITE-1:0]             wr_en,
  input  logic [NUM_WRITE-1:0][ADDR_W-1:0] wr_addr,
  input  logic [NUM_WRITE-1:0][XLEN-1:0]   wr_data,
  input  logic                             rsv_en,
  input  logic [ADDR_W-1:0]                rsv_addr,
  input  logic                             flush,
  output logic [ADDR_W:0]                  busy_count
);
  localparam int NUM_REGS = 1 << ADDR_W;

  logic [NUM_REGS-1:0][XLEN-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0]           busy_q, busy_d;
  logic [NUM_REGS-1:0]           wr_hit, rsv_hit, clr_vec;
  logic [ADDR_W:0]               busy_count_q, busy_count_d, clr_cnt;
  logic                          fwd_en, rsv_vld, rsv_new;

  assign fwd_en  = (USE_FORWARDING != 0) && !reset;
  assign rsv_vld = rsv_en && (rsv_addr != '0);
  assign rsv_new = rsv_vld && !busy_q[rsv_addr];

  always_comb begin
    regs_d = regs_q;
    wr_hit = '0;
    for (int p = 0; p < NUM_WRITE; p++) begin
      if (wr_en[p] && (wr_addr[p] != '0)) begin
        regs_d[wr_addr[p]] = wr_data[p];
        wr_hit[wr_addr[p]] = 1'b1;
      end
    end
    regs_d[0] = '0;
  end

  // Reservation beats a coincident writeback: the new producer is still pending.
  always_comb begin
    rsv_hit = '0;
    if (rsv_vld) rsv_hit[rsv_addr] = 1'b1;
    busy_d  = flush ? rsv_hit : ((busy_q & ~wr_hit) | rsv_hit);
    clr_vec = busy_q & wr_hit & ~rsv_hit;
  end

  // Incremental count; wr_hit is per register, so duplicate writes count once.
  always_comb begin
    clr_cnt = '0;
    for (int r = 0; r < NUM_REGS; r++)
      clr_cnt = clr_cnt + {{ADDR_W{1'b0}}, clr_vec[r]};
    if (flush)
      busy_count_d = {{ADDR_W{1'b0}}, rsv_vld};
    else
      busy_count_d = busy_count_q - clr_cnt + {{ADDR_W{1'b0}}, rsv_new};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q       <= '0;
      busy_q       <= '0;
      busy_count_q <= '0;
    end else begin
      regs_q       <= regs_d;
      busy_q       <= busy_d;
      busy_count_q <= busy_count_d;
    end
  end

  assign busy_count = busy_count_q;

  for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
    register_file_mp_rd_port #(
      .XLEN(XLEN), .ADDR_W(ADDR_W), .NUM_WRITE(NUM_WRITE)
    ) u_rd (
      .addr    (rd_addr[i]),
      .regs_q  (regs_q),
      .busy_q  (busy_q),
      .fwd_en  (fwd_en),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .data    (rd_data[i]),
      .busy    (rd_busy[i])
    );
  end
endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp: vector table on a forwarding instance, hand
// sequences for reset and a non-forwarding instance, popcount model check.

module tb_register_file_mp;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [1:0][4:0]  rd_addr, rd_addr_n;
  logic [1:0][31:0] rd_data, rd_data_n;
  logic [1:0]       rd_busy, rd_busy_n;
  logic [1:0]       wr_en, wr_en_n;
  logic [1:0][4:0]  wr_addr, wr_addr_n;
  logic [1:0][31:0] wr_data, wr_data_n;
  logic             rsv_en, rsv_en_n, flush, flush_n;
  logic [4:0]       rsv_addr, rsv_addr_n;
  logic [5:0]       busy_count, busy_count_n;

  register_file_mp #(.USE_FORWARDING(1)) dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en),
    .rsv_addr(rsv_addr), .flush(flush), .busy_count(busy_count));

  register_file_mp #(.USE_FORWARDING(0)) dut_nf (
    .clk(clk), .reset(reset), .rd_addr(rd_addr_n), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
    .wr_en(wr_en_n), .wr_addr(wr_addr_n), .wr_data(wr_data_n), .rsv_en(rsv_en_n),
    .rsv_addr(rsv_addr_n), .flush(flush_n), .busy_count(busy_count_n));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference busy bits for the forwarding instance, built from the scoreboard rules.
  logic [31:0] model_busy = '0;
  bit          model_on   = 1'b0;
  always @(posedge clk) begin
    logic [31:0] nb;
    nb = model_busy;
    if (reset) nb = '0;
    else begin
      if (flush) nb = '0;
      else
        for (int p = 0; p < 2; p++)
          if (wr_en[p] && wr_addr[p] != 0) nb[wr_addr[p]] = 1'b0;
      if (rsv_en && rsv_addr != 0) nb[rsv_addr] = 1'b1;
    end
    model_busy <= nb;
  end
  always @(negedge clk)
    if (model_on) chk("busy_count_vs_popcount", 32'(busy_count), 32'($countones(model_busy)));

  task automatic dump();
    for (int r = 1; r < 32; r++)
      if (dut.regs_q[r] != 0 || dut.busy_q[r])
        $display("  x%0d = 0x%08h busy=%0d", r, dut.regs_q[r], dut.busy_q[r]);
  endtask

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0; logic [31:0] wd0;
    logic [4:0]  wa1; logic [31:0] wd1;
    logic        rsv; logic [4:0]  ra; logic fl;
    logic [4:0]  r0, r1;
    logic [31:0] e0, e1;
    logic [1:0]  eb;
    logic [5:0]  ecnt;
  } vec_t;

  function automatic vec_t mk(logic [1:0] we, logic [4:0] wa0, logic [31:0] wd0,
      logic [4:0] wa1, logic [31:0] wd1, logic rsv, logic [4:0] ra, logic fl,
      logic [4:0] r0, logic [4:0] r1, logic [31:0] e0, logic [31:0] e1,
      logic [1:0] eb, logic [5:0] ecnt);
    vec_t v;
    v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
    v.rsv = rsv; v.ra = ra; v.fl = fl; v.r0 = r0; v.r1 = r1;
    v.e0 = e0; v.e1 = e1; v.eb = eb; v.ecnt = ecnt;
    return v;
  endfunction

  vec_t tbl[$];

  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0; rsv_en = 0; rsv_addr = 0; flush = 0;
    wr_en_n = '0; wr_addr_n = '0; wr_data_n = '0; rsv_en_n = 0; rsv_addr_n = 0; flush_n = 0;
  endtask

  initial begin
    int rl[8] = '{1, 2, 3, 5, 6, 7, 9, 10};
    //            we     wa0 wd0  wa1 wd1  rsv ra fl  r0 r1  e0   e1   eb     cnt
    tbl.push_back(mk(2'b11, 5, 100, 6, 200, 0, 0, 0, 5, 6, 100, 200, 2'b00, 0));
    tbl.push_back(mk(2'b00, 0, 0,   0, 0,   0, 0, 0, 5, 6, 100, 200, 2'b00, 0));
    tbl.push_back(mk(2'b11, 7, 11,  7, 22,  0, 0, 0, 7, 5, 22,  100, 2'b00, 0));
    tbl.push_back(mk(2'b01, 0, 55,  0, 0,   0, 0, 0, 0, 7, 0,   22,  2'b00, 0));
    tbl.push_back(mk(2'b00, 0, 0,   0, 0,   1, 3, 0, 3, 4, 0,   0,   2'b00, 1));
    tbl.push_back(mk(2'b00, 0, 0,   0, 0,   1, 4, 0, 3, 4, 0,   0,   2'b01, 2));
    tbl.push_back(mk(2'b00, 0, 0,   0, 0,   1, 3, 0, 3, 4, 0,   0,   2'b11, 2));
    tbl.push_back(mk(2'b01, 3, 9,   0, 0,   0, 0, 0, 3, 4, 9,   0,   2'b10, 1));
    tbl.push_back(mk(2'b10, 0, 0,   8, 4,   1, 8, 0, 8, 3, 4,   9,   2'b00, 2));
    tbl.push_back(mk(2'b00, 0, 0,   0, 0,   0, 0, 0, 8, 4, 4,   0,   2'b11, 2));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(2'b00, 0, 0, 0, 0, 1, 5'(rl[i]), 0, 4, 8, 0, 4, 2'b11, 6'(3 + i)));
    tbl.push_back(mk(2'b00, 0, 0,   0, 0,   1, 4,  0, 4,  8,  0, 4,  2'b11, 10));
    tbl.push_back(mk(2'b00, 0, 0,   0, 0,   1, 12, 1, 12, 1,  0, 0,  2'b10, 1));
    tbl.push_back(mk(2'b00, 0, 0,   0, 0,   0, 0,  0, 12, 1,  0, 0,  2'b01, 1));
    tbl.push_back(mk(2'b00, 0, 0,   0, 0,   1, 13, 0, 12, 13, 0, 0,  2'b01, 2));
    tbl.push_back(mk(2'b11, 12, 5,  13, 6,  0, 0,  0, 12, 13, 5, 6,  2'b00, 0));
    tbl.push_back(mk(2'b00, 0, 0,   0, 0,   1, 14, 0, 14, 0,  0, 0,  2'b00, 1));
    tbl.push_back(mk(2'b11, 14, 1,  14, 2,  0, 0,  0, 14, 14, 2, 2,  2'b00, 0));
    tbl.push_back(mk(2'b10, 0, 0,   31, 32'hFFFF_FFFF, 0, 0, 0, 31, 0, 32'hFFFF_FFFF, 0, 2'b00, 0));
    tbl.push_back(mk(2'b00, 0, 0,   0, 0,   1, 0,  1, 0,  31, 0, 32'hFFFF_FFFF, 2'b00, 0));
    tbl.push_back(mk(2'b00, 0, 0,   0, 0,   0, 0,  0, 7,  3,  22, 9, 2'b00, 0));

    reset = 1'b1; idle(); rd_addr = '0; rd_addr_n = '0;
    @(posedge clk); #1;
    // Forwarding must be suppressed while reset is held.
    wr_en = 2'b01; wr_addr[0] = 5; wr_data[0] = 123; rsv_en = 1; rsv_addr = 5;
    rd_addr[0] = 5;
    #1;
    chk("reset_no_fwd_data", rd_data[0], 0);
    chk("reset_no_fwd_busy", 32'(rd_busy[0]), 0);
    @(posedge clk); #1;
    reset = 1'b0; idle(); model_on = 1'b1;
    #1;
    chk("reset_write_ignored", rd_data[0], 0);
    chk("reset_busy_count", 32'(busy_count), 0);
    chk("reset_rsv_ignored", 32'(rd_busy[0]), 0);

    for (int i = 0; i < tbl.size(); i++) begin
      vec_t v;
      v = tbl[i];
      wr_en = v.we; wr_addr[0] = v.wa0; wr_data[0] = v.wd0;
      wr_addr[1] = v.wa1; wr_data[1] = v.wd1;
      rsv_en = v.rsv; rsv_addr = v.ra; flush = v.fl;
      rd_addr[0] = v.r0; rd_addr[1] = v.r1;
      #1;
      chk($sformatf("row%0d_rd0", i), rd_data[0], v.e0);
      chk($sformatf("row%0d_rd1", i), rd_data[1], v.e1);
      chk($sformatf("row%0d_busy", i), 32'(rd_busy), 32'(v.eb));
      @(posedge clk); #1;
      chk($sformatf("row%0d_count", i), 32'(busy_count), 32'(v.ecnt));
    end
    idle();

    // Non-forwarding instance: same-cycle read sees stored state only.
    rsv_en_n = 1; rsv_addr_n = 2;
    @(posedge clk); #1;
    rsv_en_n = 0;
    chk("nf_count_rsv", 32'(busy_count_n), 1);
    wr_en_n = 2'b01; wr_addr_n[0] = 2; wr_data_n[0] = 77; rd_addr_n[0] = 2;
    #1;
    chk("nf_same_cycle_data", rd_data_n[0], 0);
    chk("nf_same_cycle_busy", 32'(rd_busy_n[0]), 1);
    @(posedge clk); #1;
    wr_en_n = '0;
    #1;
    chk("nf_next_data", rd_data_n[0], 77);
    chk("nf_next_busy", 32'(rd_busy_n[0]), 0);
    chk("nf_next_count", 32'(busy_count_n), 0);

    // Mid-run reset with activity pending.
    rsv_en = 1; rsv_addr = 9;
    @(posedge clk); #1;
    chk("pre_reset_count", 32'(busy_count), 1);
    reset = 1'b1;
    wr_en = 2'b01; wr_addr[0] = 5; wr_data[0] = 1; rsv_en = 1; rsv_addr = 6;
    rd_addr[0] = 5; rd_addr[1] = 6;
    #1;
    chk("reset_cycle_rd0", rd_data[0], 100);
    chk("reset_cycle_rd1", rd_data[1], 200);
    dump();
    @(posedge clk); #1;
    reset = 1'b0; idle();
    #1;
    chk("post_reset_rd0", rd_data[0], 0);
    chk("post_reset_rd1", rd_data[1], 0);
    chk("post_reset_busy", 32'(rd_busy), 0);
    chk("post_reset_count", 32'(busy_count), 0);
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
Parametrised multi-port register file for the superscalar / multi-issue pipeline. It has NUM_READ read ports and NUM_WRITE write ports, with optional same-cycle write-to-read forwarding. It also contains an integrated busy-bit scoreboard: issue reserves a destination register, writeback releases it. Register 0 is hardwired to zero and is never busy.

Parameters:
XLEN, 32, data word width in bits.
ADDR_W, 5, register address width; NUM_REGS = 1<<ADDR_W, registers 1..NUM_REGS-1 are stored.
NUM_READ, 2, number of combinational read ports (>=1).
NUM_WRITE, 2, number of write ports (>=1).
USE_FORWARDING, 1, 1 = a same-cycle write is visible on read ports; 0 = reads see stored state only.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  synchronous, active-high.
rd_addr  input  NUM_READ x ADDR_W  read addresses.
rd_data  output  NUM_READ x XLEN  read data, combinational.
rd_busy  output  NUM_READ  1 = addressed register has an outstanding reservation, combinational.
wr_en  input  NUM_WRITE  per-port write enable.
wr_addr  input  NUM_WRITE x ADDR_W  write addresses.
wr_data  input  NUM_WRITE x XLEN  write data.
rsv_en  input  1  reserve a destination register this cycle.
rsv_addr  input  ADDR_W  register to reserve.
flush  input  1  clear all busy bits; register contents are kept.
busy_count  output  ADDR_W+1  number of registers currently busy, registered.

Behaviour:
- Reset: reset is synchronous, active-high; clock is clk. On a rising edge with reset=1:
  - all stored registers become 0, all busy bits 0, busy_count 0;
  - writes, reservations and flush in that cycle are ignored.
- While reset=1, forwarding is disabled, so rd_data shows stored values only and rd_busy shows stored busy bits only.
- Read:
  - rd_addr==0 gives rd_data=0 and rd_busy=0.
  - Otherwise, when USE_FORWARDING=1 and reset=0, rd_data is the wr_data of the highest-index port p with wr_en[p] and wr_addr[p]==rd_addr. With no such port, rd_data is the stored value.
  - Read latency is 0 (combinational). A write is visible in stored state the cycle after its edge.
- Write:
  - Each port with wr_en=1 and wr_addr!=0 updates its register at the rising edge.
  - If several ports target the same address, the highest port index wins.
  - Writes to x0 are discarded.
- Scoreboard:
  - A write (any port, addr!=0) clears that register's busy bit at the edge.
  - rsv_en with rsv_addr!=0 sets the busy bit at the edge.
  - If a reservation and a write hit the same address in the same cycle, the reservation wins and the register stays busy (the new producer is pending).
  - flush=1 clears every busy bit at the edge. A reservation in the same cycle as flush still takes effect: flush first, then reserve.
  - Reserving an already-busy register is legal; the bit stays 1 and busy_count is unchanged.
- rd_busy with USE_FORWARDING=1: rd_busy = stored_busy AND NOT (a same-cycle write to that address). Same-cycle reservations are not reflected in rd_busy.
- rd_busy with USE_FORWARDING=0: rd_busy = stored_busy.
- busy_count:
  - Registered, equal to the popcount of the busy bits after the edge.
  - Maintained incrementally: +1 for a reservation of a non-busy register, -1 for each distinct non-busy-after-edge register whose bit was cleared by a write.
  - Set to 0 on flush, or to 1 if flush coincides with a valid reservation.
  - Must never underflow or exceed NUM_REGS-1.
  - A bench assertion checks it equals the popcount every cycle.
- Debug: a non-synthesised dump task prints nonzero registers and busy bits, matching the existing register-file dump style.

Test Plan:
- Reset then all-port write: write port0 r5=100 and port1 r6=200 in one cycle. Next cycle, rd_addr={5,6} gives rd_data={100,200}. Then assert reset for 1 cycle: both read 0 and busy_count=0.
- Collision: port0 and port1 both write r7 (11 and 22) in the same cycle. With forwarding, reads that cycle return 22, and the stored value afterwards is 22. A write of 55 to r0 leaves rd_data for r0 at 0.
- Scoreboard: reserve r3, r4, r3 on consecutive cycles, giving busy_count 1, 2, 2. Then write r3=9 gives rd_busy(r3)=0 in the write cycle (forwarding), rd_data=9, and busy_count=1 after the edge.
- Reserve+write same address: rsv r8 and write r8=4 in the same cycle. Afterwards rd_busy(r8)=1, data=4, busy_count+1.
- Flush: with r1..r10 reserved (busy_count=10), pulse flush together with rsv r12. Afterwards only r12 is busy and busy_count=1.
- USE_FORWARDING=0 instance: write r2=77. The same-cycle read returns the old value 0 and rd_busy is unchanged. The next cycle returns 77.
